// File: rtl/ama_riscv_mem_arb_pkg.sv
// Shared types and defaults for the icache/dcache to main-memory arbiter.
package ama_riscv_mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned LINE_W_DEF = 128;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ_IC  = 3'd1,
      REQ_DC  = 3'd2,
      WAIT_IC = 3'd3,
      WAIT_DC = 3'd4
   } arb_state_t;

   typedef enum logic {
      SRC_IC = 1'b0,
      SRC_DC = 1'b1
   } arb_src_t;

   function automatic logic is_req_state(arb_state_t s);
      return (s == REQ_IC) || (s == REQ_DC);
   endfunction

endpackage

// File: rtl/ama_riscv_mem_arb_pick.sv
// Grant select between icache and dcache requests.
// MEM_ARB_RR_EN: 2-way round robin with a last-granted pointer; otherwise dcache has fixed priority.
module ama_riscv_mem_arb_pick
   import ama_riscv_mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic ic_valid,
   input  logic dc_valid,
   output logic grant_ic,
   output logic grant_dc
);

`ifdef MEM_ARB_RR_EN
   arb_src_t last;

   always_ff @(posedge clk) begin
      if (rst) begin
         last <= SRC_IC;
      end else if (grant_ic || grant_dc) begin
         last <= grant_dc ? SRC_DC : SRC_IC;
      end
   end

   // On a tie, favour the side that was not granted last.
   always_comb begin
      grant_dc = en && dc_valid && (!ic_valid || (last == SRC_IC));
      grant_ic = en && ic_valid && !grant_dc;
   end
`else
   logic unused_clk_rst;
   assign unused_clk_rst = ^{clk, rst};

   always_comb begin
      grant_dc = en && dc_valid;
      grant_ic = en && ic_valid && !dc_valid;
   end
`endif

endmodule

// File: rtl/ama_riscv_mem_arb.sv
// Single-outstanding arbiter between icache fills and dcache fills/writebacks toward main memory.
// Arbitration policy selected by MEM_ARB_RR_EN (round robin) versus fixed dcache priority.
module ama_riscv_mem_arb
   import ama_riscv_mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned LINE_W = LINE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req_valid,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_req_ready,
   output logic              ic_rsp_valid,
   output logic [LINE_W-1:0] ic_rsp_data,
   input  logic              dc_req_valid,
   input  logic              dc_req_we,
   input  logic [ADDR_W-1:0] dc_req_addr,
   input  logic [LINE_W-1:0] dc_req_wdata,
   output logic              dc_req_ready,
   output logic              dc_rsp_valid,
   output logic [LINE_W-1:0] dc_rsp_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_req_we,
   output logic [LINE_W-1:0] mem_req_wdata,
   input  logic              mem_rsp_valid,
   input  logic [LINE_W-1:0] mem_rsp_data
);

   arb_state_t state;
   logic       pick_en;
   logic       grant_ic;
   logic       grant_dc;

   // Outputs are gated by rst so nothing leaks in the cycle reset is first sampled.
   assign pick_en = !rst && (state == IDLE);

   ama_riscv_mem_arb_pick u_pick (
      .clk      (clk),
      .rst      (rst),
      .en       (pick_en),
      .ic_valid (ic_req_valid),
      .dc_valid (dc_req_valid),
      .grant_ic (grant_ic),
      .grant_dc (grant_dc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         mem_req_addr  <= '0;
         mem_req_we    <= 1'b0;
         mem_req_wdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_dc) begin
                  state         <= REQ_DC;
                  mem_req_addr  <= dc_req_addr;
                  mem_req_we    <= dc_req_we;
                  mem_req_wdata <= dc_req_wdata;
               end else if (grant_ic) begin
                  state         <= REQ_IC;
                  mem_req_addr  <= ic_req_addr;
                  mem_req_we    <= 1'b0;
                  mem_req_wdata <= '0;
               end
            end
            REQ_IC:  if (mem_req_ready) state <= WAIT_IC;
            REQ_DC:  if (mem_req_ready) state <= WAIT_DC;
            WAIT_IC: if (mem_rsp_valid) state <= IDLE;
            WAIT_DC: if (mem_rsp_valid) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      ic_req_ready  = grant_ic;
      dc_req_ready  = grant_dc;
      mem_req_valid = !rst && is_req_state(state);
      ic_rsp_valid  = !rst && (state == WAIT_IC) && mem_rsp_valid;
      dc_rsp_valid  = !rst && (state == WAIT_DC) && mem_rsp_valid;
      ic_rsp_data   = ic_rsp_valid ? mem_rsp_data : '0;
      // Writeback acks return zero data.
      dc_rsp_data   = (dc_rsp_valid && !mem_req_we) ? mem_rsp_data : '0;
   end

endmodule

// File: doc/ama_riscv_mem_arb.md
AMA_RISCV_MEM_ARB -- requirements
Module: ama_riscv_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 32, memory byte-address width.
REQ-002 Parameter LINE_W, default 128, cache-line data width in bits.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; ports are clk and rst.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 ic_req_valid  in  1  icache line-fill request.
REQ-007 ic_req_addr  in  ADDR_W  icache fill address, line-aligned.
REQ-008 ic_req_ready  out  1  icache request accepted this cycle.
REQ-009 ic_rsp_valid  out  1  icache fill data valid, one-cycle pulse.
REQ-010 ic_rsp_data  out  LINE_W  icache fill data.
REQ-011 dc_req_valid  in  1  dcache request: fill or writeback.
REQ-012 dc_req_we  in  1  1 = writeback, 0 = fill.
REQ-013 dc_req_addr  in  ADDR_W  dcache address, line-aligned.
REQ-014 dc_req_wdata  in  LINE_W  writeback data.
REQ-015 dc_req_ready  out  1  dcache request accepted this cycle.
REQ-016 dc_rsp_valid  out  1  dcache fill data or write ack, one-cycle pulse.
REQ-017 dc_rsp_data  out  LINE_W  dcache fill data; all zeros on write ack.
REQ-018 mem_req_valid  out  1  request to main memory.
REQ-019 mem_req_ready  in  1  main memory accepts request.
REQ-020 mem_req_addr / mem_req_we / mem_req_wdata  out  ADDR_W / 1 / LINE_W  registered request payload.
REQ-021 mem_rsp_valid  in  1  memory response (read data or write ack).
REQ-022 mem_rsp_data  in  LINE_W  memory read data.

Function
REQ-023 FSM states: IDLE, REQ_IC, REQ_DC, WAIT_IC, WAIT_DC; exactly one outstanding memory transaction at any time.
REQ-024 IDLE: at most one requester is granted per cycle; the granted side's *_req_ready is 1 for exactly that cycle, its payload is latched, and the next state is REQ_IC or REQ_DC.
REQ-025 *_req_ready SHALL be 0 in every state other than IDLE; a non-granted request stays pending and is not dropped.
REQ-026 REQ_x: mem_req_valid = 1 with the latched payload; mem_req_valid SHALL be held and the payload kept stable until mem_req_ready = 1, then go to WAIT_x.
REQ-027 WAIT_x: on mem_rsp_valid, pulse x_rsp_valid in the same cycle with x_rsp_data = mem_rsp_data (zeros for write acks), then go to IDLE.
REQ-028 A new grant SHALL NOT occur in the cycle a response is returned; minimum requester-to-requester turnaround is 1 IDLE cycle.
REQ-029 Best-case latency: ready in cycle N, mem_req_valid in N+1, response no earlier than N+2.
REQ-030 mem_rsp_valid outside WAIT_IC/WAIT_DC SHALL be ignored; no rsp pulse is produced.
REQ-031 mem_req_we is 0 for every icache transaction.

Reset
REQ-032 While rst = 1: state = IDLE, all *_valid and *_ready outputs = 0, latched payload = 0, round-robin pointer = icache.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction without producing a response pulse; the memory side is responsible for its own reset.

Configuration
REQ-034 Macro MEM_ARB_RR_EN defined: 2-way round robin; on simultaneous requests, grant the side not granted last; the pointer updates on every grant.
REQ-035 MEM_ARB_RR_EN undefined: fixed priority, dcache always wins simultaneous requests; no pointer state exists.

Structure
REQ-036 arb_state_t, arb_src_t (SRC_IC, SRC_DC) and the LINE_W default SHALL live in the shared ama_riscv package/defines.
REQ-037 One sub-module ama_riscv_mem_arb_pick: combinational grant select plus round-robin pointer flop (pointer present only with MEM_ARB_RR_EN).

Verification
REQ-038 ic_req_valid=1 at addr 0x100 only; mem_req_ready=1 immediately; mem_rsp after 3 cycles with data 0xA5..A5 -> ic_req_ready in cycle 0, mem_req_valid in cycle 1, ic_rsp_valid pulse carrying 0xA5..A5, dc_rsp_valid stays 0.
REQ-039 ic and dc both valid in the same cycle, repeated 4 times -> with MEM_ARB_RR_EN grant order DC,IC,DC,IC (pointer starts at icache); without it DC,DC,DC,DC while ic stays pending.
REQ-040 dc writeback at addr 0x2000 with wdata 0x1234; mem_req_ready held 0 for 5 cycles -> mem_req_valid held high and payload stable for all 5 cycles; dc_rsp_valid on ack with data 0.
REQ-041 mem_rsp_valid injected while in IDLE and in REQ_DC -> no rsp pulse on either side, FSM state unchanged.
REQ-042 rst asserted in WAIT_IC, then mem_rsp_valid arrives -> no ic_rsp_valid, all outputs 0, next request is accepted normally after reset.
